// File: rtl/display_scan_ctrl.sv
// Time-multiplexed 7-segment scan controller: BLANK/SHOW per digit, shadowed value loads at frame boundaries.
// Optional `define LEADING_ZERO_BLANK_EN keeps leading-zero digits (other than digit 0) dark.
module display_scan_ctrl #(
  parameter int NUM_DIGITS   = 4,
  parameter int SHOW_CYCLES  = 50000,
  parameter int BLANK_CYCLES = 500
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [4*NUM_DIGITS-1:0]   value,
  input  logic                      load,
  output logic [3:0]                digit_code,
  output logic [NUM_DIGITS-1:0]     an_n,
  output logic                      frame_done,
  output logic                      pending
);

  localparam int CMAX = (SHOW_CYCLES > BLANK_CYCLES) ? SHOW_CYCLES : BLANK_CYCLES;
  localparam int CW   = $clog2(CMAX + 1);
  localparam int IW   = $clog2(NUM_DIGITS);
  localparam logic [CW-1:0] SHOW_LAST  = CW'(SHOW_CYCLES - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
  localparam logic [IW-1:0] LAST_IDX   = IW'(NUM_DIGITS - 1);

  typedef enum logic {ST_BLANK = 1'b0, ST_SHOW = 1'b1} state_t;

  state_t                    r_state, w_state_next;
  logic [CW-1:0]             r_cnt, w_cnt_next;
  logic [IW-1:0]             r_idx, w_idx_next;
  logic [4*NUM_DIGITS-1:0]   r_active, r_shadow, w_active_next;
  logic                      r_pending;
  logic [3:0]                r_code, w_code_next;
  logic                      w_show_end, w_blank_end, w_frame_end;
  logic [NUM_DIGITS-1:0]     w_dark;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_BLANK;
      r_cnt   <= '0;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_idx   <= w_idx_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt + 1'b1;
    w_idx_next   = r_idx;
    w_blank_end  = (r_state == ST_BLANK) && (r_cnt == BLANK_LAST);
    w_show_end   = (r_state == ST_SHOW) && (r_cnt == SHOW_LAST);
    w_frame_end  = w_show_end && (r_idx == LAST_IDX);
    if (w_blank_end) begin
      w_state_next = ST_SHOW;
      w_cnt_next   = '0;
    end else if (w_show_end) begin
      w_state_next = ST_BLANK;
      w_cnt_next   = '0;
      w_idx_next   = (r_idx == LAST_IDX) ? '0 : r_idx + 1'b1;
    end
  end

  // A load coinciding with the frame boundary bypasses the shadow so it is never lost.
  always_comb begin
    w_active_next = r_active;
    if (w_frame_end) begin
      if (load)           w_active_next = value;
      else if (r_pending) w_active_next = r_shadow;
    end
  end

  // The code for the next digit is taken from the post-boundary active value so a frame never mixes loads.
  always_comb begin
    w_code_next = 4'h0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (w_idx_next == IW'(i)) w_code_next = w_active_next[4*i +: 4];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_active  <= '0;
      r_shadow  <= '0;
      r_pending <= 1'b0;
      r_code    <= 4'h0;
    end else begin
      r_active <= w_active_next;
      if (w_frame_end) begin
        r_pending <= 1'b0;
      end else if (load) begin
        r_shadow  <= value;
        r_pending <= 1'b1;
      end
      if (w_show_end) r_code <= w_code_next;
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  always_comb begin
    logic v_zero_above;
    v_zero_above = 1'b1;
    w_dark       = '0;
    for (int i = NUM_DIGITS - 1; i > 0; i--) begin
      v_zero_above = v_zero_above && (r_active[4*i +: 4] == 4'h0);
      w_dark[i]    = v_zero_above;
    end
  end
`else
  assign w_dark = '0;
`endif

  // Enables decode straight from the state register so reset darkens the display asynchronously.
  always_comb begin
    an_n       = '1;
    frame_done = w_frame_end;
    if (r_state == ST_SHOW) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if ((r_idx == IW'(i)) && !w_dark[i]) an_n[i] = 1'b0;
      end
    end
  end

  assign digit_code = r_code;
  assign pending    = r_pending;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Scoreboard bench for display_scan_ctrl (4 digits, 8 show / 2 blank cycles); expected SHOW periods
// are queued by the stimulus and popped by a monitor at the end of each observed SHOW period.
module tb_display_scan_ctrl;

  localparam int ND = 4;
  localparam int W  = 16;

  logic          clk;
  logic          rst_n;
  logic [15:0]   value;
  logic          load;
  logic [3:0]    digit_code;
  logic [ND-1:0] an_n;
  logic          frame_done;
  logic          pending;

  display_scan_ctrl #(
    .NUM_DIGITS  (ND),
    .SHOW_CYCLES (8),
    .BLANK_CYCLES(2)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .value      (value),
    .load       (load),
    .digit_code (digit_code),
    .an_n       (an_n),
    .frame_done (frame_done),
    .pending    (pending)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int            n_checks = 0;
  int            n_pass   = 0;
  logic [W-1:0]  exp_q[$];
  bit            mon_en   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, expv);
  endtask

  // expected entry: {code, an_n, show length}
  task automatic push_frame(input logic [15:0] v, input int ndig);
    for (int i = 0; i < ndig; i++) begin
      logic [15:0] upper;
      logic [3:0]  nib;
      logic [3:0]  an;
      bit          shown;
      upper = v >> (4 * i);
      nib   = upper[3:0];
      an    = ~(4'b0001 << i);
      shown = 1;
`ifdef LEADING_ZERO_BLANK_EN
      if (i > 0 && upper == 16'h0) shown = 0;
`endif
      if (shown) exp_q.push_back({nib, an, 8'd8});
    end
  endtask

  // driver tasks
  task automatic do_load(input logic [15:0] v);
    @(negedge clk);
    value = v;
    load  = 1'b1;
    @(negedge clk);
    load  = 1'b0;
  endtask

  task automatic wait_fd();
    bit got;
    got = 0;
    for (int k = 0; k < 100 && !got; k++) begin
      @(negedge clk);
      if (frame_done) got = 1;
    end
    if (!got) check("frame_done_timeout", 32'd0, 32'd1);
  endtask

  // monitor
  bit          prev_on, run_ok, fd_prev, have_prev;
  logic [3:0]  cur_an, cur_code;
  int          run_len, fd_gap;

  always @(negedge clk) begin
    if (!rst_n || !mon_en) begin
      prev_on   = 0;
      fd_prev   = 0;
      have_prev = 0;
      fd_gap    = 0;
    end else begin
      bit on;
      on = (an_n != 4'hF);
      if (on) begin
        if (!prev_on) begin
          cur_an   = an_n;
          cur_code = digit_code;
          run_len  = 1;
          run_ok   = ($countones(~an_n) == 1);
        end else begin
          run_len++;
          if (an_n != cur_an || digit_code != cur_code) run_ok = 0;
        end
      end else if (prev_on) begin
        if (exp_q.size() == 0) begin
          check("show_unexpected", 32'd0, 32'd1);
        end else begin
          logic [W-1:0] e;
          e = exp_q.pop_front();
          check("show_period", {16'h0, cur_code, cur_an, run_len[7:0]}, {16'h0, e});
          check("show_stable_onehot", {31'h0, run_ok}, 32'd1);
        end
      end
      prev_on = on;
      fd_gap++;
      if (frame_done) begin
        check("frame_done_width", {31'h0, fd_prev}, 32'd0);
        if (have_prev) check("frame_period", fd_gap, 40);
        have_prev = 1;
        fd_gap    = 0;
      end
      fd_prev = frame_done;
    end
  end

  // stimulus
  initial begin
    rst_n = 1'b0;
    value = 16'h0;
    load  = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_an_n", {28'h0, an_n}, 32'hF);
    check("rst_code", {28'h0, digit_code}, 32'h0);
    check("rst_frame_done", {31'h0, frame_done}, 32'h0);
    check("rst_pending", {31'h0, pending}, 32'h0);
    push_frame(16'h0000, ND);
    mon_en = 1;
    rst_n  = 1'b1;

    do_load(16'h1234);
    check("pending_after_load", {31'h0, pending}, 32'd1);
    wait_fd();
    check("pending_at_boundary", {31'h0, pending}, 32'd1);
    push_frame(16'h1234, ND);
    @(negedge clk);
    check("pending_cleared", {31'h0, pending}, 32'd0);

    do_load(16'hAAAA);
    repeat (3) @(negedge clk);
    do_load(16'h5555);
    check("pending_two_loads", {31'h0, pending}, 32'd1);
    wait_fd();
    check("pending_latest_boundary", {31'h0, pending}, 32'd1);
    push_frame(16'h5555, ND);
    @(negedge clk);
    check("pending_cleared2", {31'h0, pending}, 32'd0);

    wait_fd();
    value = 16'hBEEF;
    load  = 1'b1;
    push_frame(16'hBEEF, ND);
    @(negedge clk);
    load  = 1'b0;
    check("pending_direct_load", {31'h0, pending}, 32'd0);

    do_load(16'h0070);
    wait_fd();
    push_frame(16'h0070, ND);
    @(negedge clk);

    wait_fd();
    push_frame(16'h0070, 2);
    do_load(16'h9999);
    check("pending_before_reset", {31'h0, pending}, 32'd1);
    repeat (23) @(negedge clk);
    #2;
`ifdef LEADING_ZERO_BLANK_EN
    check("digit2_dark", {28'h0, an_n}, 32'hF);
`else
    check("digit2_showing", {28'h0, an_n}, 32'hB);
`endif
    rst_n = 1'b0;
    #1;
    check("async_rst_an_n", {28'h0, an_n}, 32'hF);
    check("async_rst_code", {28'h0, digit_code}, 32'h0);
    check("async_rst_pending", {31'h0, pending}, 32'd0);
    check("queue_drained", exp_q.size(), 0);
    repeat (2) @(negedge clk);
    push_frame(16'h0000, ND);
    rst_n = 1'b1;
    @(negedge clk);
    check("restart_blank", {28'h0, an_n}, 32'hF);
    @(negedge clk);
    check("restart_digit0", {28'h0, an_n}, 32'hE);

    wait_fd();
    push_frame(16'h0000, ND);
    wait_fd();
    repeat (5) @(negedge clk);
    mon_en = 0;
    check("queue_empty_end", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
